// File: rtl/requant_pkg.sv
// Shared types and constants for the requantization sequencer.
package requant_pkg;
   typedef enum logic [3:0] {
      IDLE, RD_ADDR, RD_WAIT, LATCH, MUL_GO, MUL_WAIT, SHF_GO, SHF_WAIT, WRITE, FIN
   } state_t;

   localparam int LANES  = 4;
   localparam int BYTE_W = 8;
   localparam logic signed [BYTE_W-1:0] INT8_MIN = -8'sd128;
   localparam logic signed [BYTE_W-1:0] INT8_MAX = 8'sd127;
endpackage

// File: rtl/requant_clamp_pack.sv
// Output offset add, signed clamp to the activation range and int8 lane packing.
module requant_clamp_pack
   import requant_pkg::*;
(
   input  logic                      clk,
   input  logic                      store,
   input  logic                      zero,
   input  logic [1:0]                lane,
   input  logic [31:0]               result,
   input  logic [31:0]               out_offset,
   input  logic [7:0]                act_min,
   input  logic [7:0]                act_max,
   output logic [LANES*BYTE_W-1:0]   pack_word
);
   logic signed [31:0] v;
   logic signed [31:0] min_ext;
   logic signed [31:0] max_ext;
   logic signed [31:0] sat;
   logic [BYTE_W-1:0]  byte_val;

   // Upper bound applied last so an inverted range collapses to act_max.
   function automatic logic signed [31:0] clamp(input logic signed [31:0] x,
                                                input logic signed [31:0] lo,
                                                input logic signed [31:0] hi);
      logic signed [31:0] t;
      t = (x < lo) ? lo : x;
      return (t > hi) ? hi : t;
   endfunction

   always_comb begin
      min_ext  = {{24{act_min[7]}}, act_min};
      max_ext  = {{24{act_max[7]}}, act_max};
      v        = signed'(result) + signed'(out_offset);
      sat      = clamp(v, min_ext, max_ext);
      byte_val = zero ? '0 : sat[BYTE_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (store) pack_word[lane*BYTE_W +: BYTE_W] <= byte_val;
   end
endmodule

// File: rtl/requant_sequencer.sv
// Post-GEMM requantization sequencer: C rows -> SRDHM -> RDBPOT -> offset/clamp -> packed int8.
// Optional handshake watchdog enabled by defining REQUANT_WATCHDOG_EN.
module requant_sequencer #(
   parameter int ADDR_BITS   = 12,
   parameter int ACC_W       = 32,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [ADDR_BITS-1:0]   c_base,
   input  logic [ADDR_BITS-1:0]   q_base,
   input  logic [ADDR_BITS-1:0]   count,
   input  logic [31:0]            multiplier,
   input  logic [4:0]             shift,
   input  logic [31:0]            out_offset,
   input  logic [7:0]             act_min,
   input  logic [7:0]             act_max,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic [ADDR_BITS-1:0]   c_index,
   input  logic [4*ACC_W-1:0]     c_data,
   output logic [ACC_W-1:0]       srdhm_a,
   output logic [31:0]            srdhm_b,
   output logic                   srdhm_valid,
   input  logic [31:0]            srdhm_result,
   input  logic                   srdhm_done,
   output logic [31:0]            rdbpot_x,
   output logic [31:0]            rdbpot_exp,
   output logic                   rdbpot_valid,
   input  logic [31:0]            rdbpot_result,
   input  logic                   rdbpot_done,
   output logic                   q_wr_en,
   output logic [ADDR_BITS-1:0]   q_index,
   output logic [31:0]            q_data
);
   import requant_pkg::*;

   state_t                 state, next_state;
   logic [ADDR_BITS-1:0]   row;
   logic [1:0]             lane;
   logic                   busy_r, done_r;
   logic                   accept, lane_adv, timeout, last_row;
   logic [ADDR_BITS-1:0]   c_base_r, q_base_r, count_r;
   logic [31:0]            mult_r, offset_r, mul_res;
   logic [4:0]             shift_r;
   logic [7:0]             min_r, max_r;
   logic [4*ACC_W-1:0]     row_data;
   logic [31:0]            pack_word;

   assign accept   = (state == IDLE) && start;
   assign last_row = (row == count_r - ADDR_BITS'(1));
   assign busy     = busy_r;
   assign done     = done_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         row    <= '0;
         lane   <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         state  <= next_state;
         done_r <= (state == FIN);
         if (accept)              busy_r <= 1'b1;
         else if (state == FIN)   busy_r <= 1'b0;
         if (state == IDLE)       row <= '0;
         else if (state == WRITE) row <= row + ADDR_BITS'(1);
         if (state == LATCH)      lane <= '0;
         else if (lane_adv)       lane <= lane + 2'd1;
      end
   end

   // Configuration and row datapath registers carry no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         c_base_r <= c_base;
         q_base_r <= q_base;
         count_r  <= count;
         mult_r   <= multiplier;
         shift_r  <= shift;
         offset_r <= out_offset;
         min_r    <= act_min;
         max_r    <= act_max;
      end
      if (state == LATCH)                  row_data <= c_data;
      if (state == MUL_WAIT && srdhm_done) mul_res  <= srdhm_result;
   end

   always_comb begin
      next_state   = state;
      lane_adv     = 1'b0;
      c_index      = '0;
      q_index      = '0;
      q_wr_en      = 1'b0;
      q_data       = '0;
      srdhm_a      = '0;
      srdhm_b      = '0;
      srdhm_valid  = 1'b0;
      rdbpot_x     = '0;
      rdbpot_exp   = '0;
      rdbpot_valid = 1'b0;
      case (state)
         IDLE:     if (start) next_state = (count == '0) ? FIN : RD_ADDR;
         RD_ADDR: begin
            c_index    = c_base_r + row;
            next_state = RD_WAIT;
         end
         RD_WAIT: begin
            c_index    = c_base_r + row;
            next_state = LATCH;
         end
         LATCH: begin
            c_index    = c_base_r + row;
            next_state = MUL_GO;
         end
         MUL_GO: begin
            srdhm_valid = 1'b1;
            srdhm_a     = row_data[lane*ACC_W +: ACC_W];
            srdhm_b     = mult_r;
            next_state  = MUL_WAIT;
         end
         MUL_WAIT: begin
            srdhm_a = row_data[lane*ACC_W +: ACC_W];
            srdhm_b = mult_r;
            if (srdhm_done) begin
               next_state = SHF_GO;
            end else if (timeout) begin
               lane_adv   = 1'b1;
               next_state = (lane == 2'd3) ? WRITE : MUL_GO;
            end
         end
         SHF_GO: begin
            rdbpot_valid = 1'b1;
            rdbpot_x     = mul_res;
            rdbpot_exp   = {27'd0, shift_r};
            next_state   = SHF_WAIT;
         end
         SHF_WAIT: begin
            rdbpot_x   = mul_res;
            rdbpot_exp = {27'd0, shift_r};
            if (rdbpot_done || timeout) begin
               lane_adv   = 1'b1;
               next_state = (lane == 2'd3) ? WRITE : MUL_GO;
            end
         end
         WRITE: begin
            q_wr_en    = 1'b1;
            q_index    = q_base_r + row;
            q_data     = pack_word;
            next_state = last_row ? FIN : RD_ADDR;
         end
         FIN:      next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   requant_clamp_pack u_pack (
      .clk        (clk),
      .store      (lane_adv),
      .zero       (timeout),
      .lane       (lane),
      .result     (rdbpot_result),
      .out_offset (offset_r),
      .act_min    (min_r),
      .act_max    (max_r),
      .pack_word  (pack_word)
   );

`ifdef REQUANT_WATCHDOG_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0] wd_cnt;
   logic          err_r;

   // Counter restarts at each launch; a stuck unit yields a zero byte and the row carries on.
   assign timeout = (((state == MUL_WAIT) && !srdhm_done) || ((state == SHF_WAIT) && !rdbpot_done))
                    && (wd_cnt == CW'(TIMEOUT_CYC - 1));
   assign err     = err_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt <= '0;
         err_r  <= 1'b0;
      end else begin
         if (state == MUL_GO || state == SHF_GO)          wd_cnt <= '0;
         else if (state == MUL_WAIT || state == SHF_WAIT) wd_cnt <= wd_cnt + CW'(1);
         if (accept)       err_r <= 1'b0;
         else if (timeout) err_r <= 1'b1;
      end
   end
`else
   logic [31:0] unused_timeout_cyc;
   assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif
endmodule

// File: tb/tb_requant_sequencer.sv
// Directed self-checking bench for requant_sequencer with behavioural SRDHM/RDBPOT units and buffers.
module tb_requant_sequencer;
   localparam int AB = 12;
   localparam int AW = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            start;
   logic [AB-1:0]   c_base, q_base, count;
   logic [31:0]     multiplier, out_offset;
   logic [4:0]      shift;
   logic [7:0]      act_min, act_max;
   logic            busy, done, err;
   logic [AB-1:0]   c_index, q_index;
   logic [4*AW-1:0] c_data;
   logic [AW-1:0]   srdhm_a;
   logic [31:0]     srdhm_b, srdhm_result, rdbpot_x, rdbpot_exp, rdbpot_result, q_data;
   logic            srdhm_valid, srdhm_done, rdbpot_valid, rdbpot_done, q_wr_en;

   always #5 clk = ~clk;

   requant_sequencer #(.ADDR_BITS(AB), .ACC_W(AW), .TIMEOUT_CYC(64)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .c_base(c_base), .q_base(q_base), .count(count),
      .multiplier(multiplier), .shift(shift), .out_offset(out_offset), .act_min(act_min),
      .act_max(act_max), .busy(busy), .done(done), .err(err), .c_index(c_index), .c_data(c_data),
      .srdhm_a(srdhm_a), .srdhm_b(srdhm_b), .srdhm_valid(srdhm_valid), .srdhm_result(srdhm_result),
      .srdhm_done(srdhm_done), .rdbpot_x(rdbpot_x), .rdbpot_exp(rdbpot_exp),
      .rdbpot_valid(rdbpot_valid), .rdbpot_result(rdbpot_result), .rdbpot_done(rdbpot_done),
      .q_wr_en(q_wr_en), .q_index(q_index), .q_data(q_data)
   );

   function automatic logic [31:0] srdhm_f(input logic signed [31:0] a, input logic signed [31:0] b);
      logic signed [63:0] ab, nudge, q;
      if (a == 32'sh80000000 && b == 32'sh80000000) return 32'h7FFFFFFF;
      ab    = a * b;
      nudge = (ab >= 0) ? 64'sd1073741824 : (64'sd1 - 64'sd1073741824);
      q     = (ab + nudge) / 64'sd2147483648;
      return q[31:0];
   endfunction

   function automatic logic [31:0] rdbpot_f(input logic signed [31:0] x, input int e);
      logic signed [31:0] mask, rem, thr, r;
      mask = (32'sd1 <<< e) - 32'sd1;
      rem  = x & mask;
      thr  = (mask >>> 1) + ((x < 0) ? 32'sd1 : 32'sd0);
      r    = (x >>> e) + ((rem > thr) ? 32'sd1 : 32'sd0);
      return r;
   endfunction

   logic [4*AW-1:0] mem [0:4095];
   always @(posedge clk) c_data <= mem[c_index];

   int          s_cnt = 0, r_cnt = 0;
   logic [1:0]  m_ph = 2'd0;
   logic        stall_en = 1'b0;
   always @(posedge clk) begin
      if (!rst_n) m_ph <= 2'd0;
      if (s_cnt > 0) s_cnt <= s_cnt - 1;
      if (srdhm_valid) begin
         srdhm_result <= srdhm_f(srdhm_a, srdhm_b);
         s_cnt        <= (stall_en && m_ph == 2'd2) ? 0 : 5;
         m_ph         <= m_ph + 2'd1;
      end
      if (r_cnt > 0) r_cnt <= r_cnt - 1;
      if (rdbpot_valid) begin
         rdbpot_result <= rdbpot_f(rdbpot_x, int'(rdbpot_exp[4:0]));
         r_cnt         <= 3;
      end
   end
   assign srdhm_done  = (s_cnt == 1);
   assign rdbpot_done = (r_cnt == 1);

   int            wr_cnt = 0, rd_cnt = 0, done_cnt = 0;
   logic [AB-1:0] wr_addr [0:255];
   logic [31:0]   wr_data [0:255];
   logic [AB-1:0] rd_addr [0:255];
   logic [AB-1:0] prev_c = '0;
   logic [1:0]    mph = 2'd0;
   always @(negedge clk) begin
      prev_c <= c_index;
      if (done) done_cnt <= done_cnt + 1;
      if (q_wr_en) begin
         wr_addr[8'(wr_cnt)] <= q_index;
         wr_data[8'(wr_cnt)] <= q_data;
         wr_cnt              <= wr_cnt + 1;
      end
      if (!rst_n) mph <= 2'd0;
      else if (srdhm_valid) begin
         if (mph == 2'd0) begin
            rd_addr[8'(rd_cnt)] <= prev_c;
            rd_cnt              <= rd_cnt + 1;
         end
         mph <= mph + 2'd1;
      end
   end

   int nvec = 0, nmis = 0;
   int wr_base, rd_base, done_base;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nmis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_cfg(input logic [AB-1:0] cb, input logic [AB-1:0] qb, input logic [AB-1:0] cn,
                          input logic [31:0] mul, input logic [4:0] sh, input logic [31:0] off,
                          input logic [7:0] mn, input logic [7:0] mx);
      c_base = cb; q_base = qb; count = cn; multiplier = mul;
      shift = sh; out_offset = off; act_min = mn; act_max = mx;
   endtask

   task automatic mark;
      wr_base = wr_cnt; rd_base = rd_cnt; done_base = done_cnt;
   endtask

   task automatic pulse_start;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (done_cnt == done_base && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_finished"}, 64'(done_cnt != done_base), 64'd1);
   endtask

   task automatic run_job(input string tag, input logic [AB-1:0] cb, input logic [AB-1:0] qb,
                          input logic [AB-1:0] cn, input logic [31:0] mul, input logic [4:0] sh,
                          input logic [31:0] off, input logic [7:0] mn, input logic [7:0] mx);
      mark();
      set_cfg(cb, qb, cn, mul, sh, off, mn, mx);
      pulse_start();
      check({tag, "_busy"}, 64'(busy), 64'd1);
      wait_done(tag, 400 * (int'(cn) + 1));
      repeat (3) @(negedge clk);
      check({tag, "_idle"}, {busy, q_wr_en, c_index}, 64'd0);
   endtask

   task automatic check_one_row(input string tag, input logic [AB-1:0] ra, input logic [AB-1:0] wa,
                                input logic [31:0] wd);
      check({tag, "_nwr"}, 64'(wr_cnt - wr_base), 64'd1);
      check({tag, "_ndone"}, 64'(done_cnt - done_base), 64'd1);
      check({tag, "_rdaddr"}, 64'(rd_addr[8'(rd_base)]), 64'(ra));
      check({tag, "_wraddr"}, 64'(wr_addr[8'(wr_base)]), 64'(wa));
      check({tag, "_data"}, 64'(wr_data[8'(wr_base)]), 64'(wd));
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not reach summary");
      $fatal(1, "global timeout");
   end

   initial begin
      int lc, n;
      for (int i = 0; i < 4096; i++) mem[i] = '0;
      mem[12'h005] = {32'hFFFFFF9C, 32'h00000000, 32'd1000, 32'd100};
      mem[12'h006] = {32'd7, 32'd0, 32'hFFF0BDC0, 32'd1000000};
      mem[12'hFFF] = {32'd4, 32'd3, 32'd2, 32'd1};
      mem[12'h000] = {32'hFFFFFFFC, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'hFFFFFFFF};
      mem[12'h001] = {32'h44, 32'h33, 32'h22, 32'h11};
      start = 1'b0;
      set_cfg('0, '0, '0, '0, '0, '0, '0, '0);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done_err", {done, err}, 64'd0);
      check("rst_bufs", {q_wr_en, c_index, q_index, q_data}, 64'd0);
      check("rst_units", {srdhm_valid, rdbpot_valid, srdhm_a, srdhm_b}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic requant, offset -128, lanes {100, 1000, 0, -100}
      run_job("basic", 12'h005, 12'h020, 12'd1, 32'h40000000, 5'd1, 32'hFFFFFF80, 8'h80, 8'h7F);
      check_one_row("basic", 12'h005, 12'h020, 32'h80807A99);
      check("basic_err", 64'(err), 64'd0);

      run_job("sat", 12'h006, 12'h021, 12'd1, 32'h7FFFFFFF, 5'd0, 32'h0, 8'h80, 8'h7F);
      check_one_row("sat", 12'h006, 12'h021, 32'h0700807F);

      run_job("narrow", 12'h005, 12'h022, 12'd1, 32'h40000000, 5'd1, 32'hFFFFFF80, 8'h9C, 8'h64);
      check_one_row("narrow", 12'h005, 12'h022, 32'h9C9C649C);

      run_job("inverted", 12'h006, 12'h023, 12'd1, 32'h7FFFFFFF, 5'd0, 32'h0, 8'h32, 8'hCE);
      check_one_row("inverted", 12'h006, 12'h023, 32'hCECECECE);

      run_job("sweep", 12'hFFF, 12'h010, 12'd3, 32'h7FFFFFFF, 5'd0, 32'h0, 8'h80, 8'h7F);
      check("sweep_nwr", 64'(wr_cnt - wr_base), 64'd3);
      check("sweep_ndone", 64'(done_cnt - done_base), 64'd1);
      check("sweep_rd", {16'(rd_addr[8'(rd_base)]), 16'(rd_addr[8'(rd_base + 1)]),
                         16'(rd_addr[8'(rd_base + 2)])}, {16'hFFF, 16'h000, 16'h001});
      check("sweep_wa", {16'(wr_addr[8'(wr_base)]), 16'(wr_addr[8'(wr_base + 1)]),
                         16'(wr_addr[8'(wr_base + 2)])}, {16'h010, 16'h011, 16'h012});
      check("sweep_d0", 64'(wr_data[8'(wr_base)]), 64'h04030201);
      check("sweep_d1", 64'(wr_data[8'(wr_base + 1)]), 64'hFCFDFEFF);
      check("sweep_d2", 64'(wr_data[8'(wr_base + 2)]), 64'h44332211);

      // count = 0: done two cycles after start, no writes
      mark();
      set_cfg(12'h005, 12'h030, 12'd0, 32'h40000000, 5'd1, 32'h0, 8'h80, 8'h7F);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      check("c0_busy", 64'(busy), 64'd1);
      check("c0_done_early", 64'(done), 64'd0);
      @(negedge clk);
      check("c0_done", {busy, done}, 64'd1);
      repeat (4) @(negedge clk);
      check("c0_nwr", 64'(wr_cnt - wr_base), 64'd0);
      check("c0_ndone", 64'(done_cnt - done_base), 64'd1);

      // Second start mid-run must be ignored
      mark();
      set_cfg(12'h005, 12'h031, 12'd1, 32'h40000000, 5'd1, 32'hFFFFFF80, 8'h80, 8'h7F);
      pulse_start();
      repeat (8) @(negedge clk);
      set_cfg(12'h006, 12'h077, 12'd3, 32'h0, 5'd3, 32'h5, 8'h00, 8'h01);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_done("rebusy", 400);
      repeat (60) @(negedge clk);
      check_one_row("rebusy", 12'h005, 12'h031, 32'h80807A99);

      // Asynchronous reset during row 1 MUL_WAIT
      mark();
      set_cfg(12'h005, 12'h040, 12'd2, 32'h40000000, 5'd1, 32'hFFFFFF80, 8'h80, 8'h7F);
      pulse_start();
      lc = 0;
      n  = 0;
      while (lc < 5 && n < 500) begin
         @(negedge clk);
         n++;
         if (srdhm_valid) lc++;
      end
      check("rmo_reach", 64'(lc), 64'd5);
      @(negedge clk);
      check("rmo_pre_a", 64'(srdhm_a), 64'd1000000);
      #2 rst_n = 1'b0;
      #1;
      check("rmo_async_ctl", {busy, done, q_wr_en, srdhm_valid, rdbpot_valid}, 64'd0);
      check("rmo_async_ops", {srdhm_a, srdhm_b}, 64'd0);
      check("rmo_async_idx", {c_index, q_index, q_data}, 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check("rmo_nwr", 64'(wr_cnt - wr_base), 64'd1);
      check("rmo_ndone", 64'(done_cnt - done_base), 64'd0);
      run_job("rerun", 12'h005, 12'h041, 12'd1, 32'h40000000, 5'd1, 32'hFFFFFF80, 8'h80, 8'h7F);
      check_one_row("rerun", 12'h005, 12'h041, 32'h80807A99);

`ifdef REQUANT_WATCHDOG_EN
      stall_en = 1'b1;
      run_job("wdog", 12'h005, 12'h050, 12'd1, 32'h40000000, 5'd1, 32'hFFFFFF80, 8'h80, 8'h7F);
      check_one_row("wdog", 12'h005, 12'h050, 32'h80007A99);
      check("wdog_err", 64'(err), 64'd1);
      stall_en = 1'b0;
      run_job("wdclr", 12'h005, 12'h051, 12'd1, 32'h40000000, 5'd1, 32'hFFFFFF80, 8'h80, 8'h7F);
      check_one_row("wdclr", 12'h005, 12'h051, 32'h80807A99);
      check("wdclr_err", 64'(err), 64'd0);
`else
      check("noerr", 64'(err), 64'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule

// File: doc/requant_sequencer.md
Name: requant_sequencer

Overview:
- Post-GEMM requantization controller between the TPU's C accumulator buffer (128-bit rows, 4 x int32 lanes) and an int8 output buffer.
- On `start`, walks `count` C rows and sends each lane through the shared SRDHM unit, then the RDBPOT unit, using their valid/done handshakes.
- Adds the output offset, clamps to the activation range, packs 4 int8 results per 32-bit word and writes one word per row.
- Replaces the CPU round-trip per accumulator; the CFU decoder starts it and polls `busy`.

Parameters:
- ADDR_BITS, 12, index width of the C and Q buffers.
- ACC_W, 32, accumulator and lane width; C row width = 4*ACC_W.
- TIMEOUT_CYC, 64, handshake watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- start  in  1  one-cycle launch pulse; ignored while busy
- c_base  in  ADDR_BITS  first C row
- q_base  in  ADDR_BITS  first Q word
- count  in  ADDR_BITS  number of rows
- multiplier  in  32  SRDHM b operand
- shift  in  5  RDBPOT exponent
- out_offset  in  32  signed output zero point
- act_min  in  8  signed clamp low
- act_max  in  8  signed clamp high
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at completion
- err  out  1  sticky watchdog flag
- c_index  out  ADDR_BITS  C read address
- c_data  in  4*ACC_W  C read data, 1-cycle BRAM latency
- srdhm_a  out  32  SRDHM a operand
- srdhm_b  out  32  SRDHM b operand
- srdhm_valid  out  1  one-cycle SRDHM launch pulse
- srdhm_result  in  32  SRDHM result
- srdhm_done  in  1  SRDHM result-valid
- rdbpot_x  out  32  RDBPOT x operand
- rdbpot_exp  out  32  RDBPOT exponent
- rdbpot_valid  out  1  one-cycle RDBPOT launch pulse
- rdbpot_result  in  32  RDBPOT result
- rdbpot_done  in  1  RDBPOT result-valid
- q_wr_en  out  1  Q write strobe
- q_index  out  ADDR_BITS  Q write address
- q_data  out  32  packed int8 word

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values:
  - All outputs are 0.
  - FSM is in IDLE; the row counter and lane counter are 0.
  - `err` is cleared.
- Accepting start:
  - A `start` in IDLE latches all configuration inputs.
  - Configuration changes while busy have no effect.
- States:
  - IDLE: on `start`, go to RD_ADDR; if `count==0`, go to FIN instead.
  - RD_ADDR: drive `c_index = c_base + row`.
  - RD_WAIT: allow for the 1-cycle BRAM latency.
  - LATCH: capture `c_data` into the row register; lane=0.
  - MUL_GO: `srdhm_valid=1` for one cycle; `srdhm_a` = lane value, `srdhm_b = multiplier`. Operands stay stable until `srdhm_done`.
  - MUL_WAIT: on `srdhm_done`, capture the result.
  - SHF_GO: `rdbpot_valid` pulse; `rdbpot_x` = SRDHM result, `rdbpot_exp` = `shift` zero-extended.
  - SHF_WAIT: on `rdbpot_done`, compute `v = rdbpot_result + out_offset` (32-bit wrap), then `sat = clamp(v, act_min, act_max)` as a signed compare. Store `sat[7:0]` in byte `lane`. If lane==3 go to WRITE, else lane+1 and back to MUL_GO.
  - WRITE: `q_wr_en=1` for one cycle with `q_index = q_base + row` and `q_data = packed`. Then row+1; if row == count-1 go to FIN, else RD_ADDR.
  - FIN: `done=1` for one cycle, `busy` low in the same cycle, then IDLE.
- Lane mapping: lane k = `c_data[32k+31:32k]` maps to `q_data[8k+7:8k]`.
- Shared-buffer discipline: `c_index`, `q_index` and `q_wr_en` are 0 outside busy, so the CFU mux may pass CPU access through when idle.
- Handshakes:
  - A `*_done` arriving in any state other than its WAIT state is ignored.
  - `*_done` in the same cycle as the `*_valid` pulse is not possible, since the units have at least 1 cycle of latency.
- Wrap-around: address adds are modulo 2^ADDR_BITS.
- Clamp range: `act_min > act_max` is not supported; the result then equals `act_max`.
- Reset mid-operation: abort immediately; no further writes; no `done`.

Optional Feature:
- Macro: REQUANT_WATCHDOG_EN.
- With the macro: a counter runs in MUL_WAIT and SHF_WAIT and reloads on each launch. Reaching TIMEOUT_CYC sets `err`, writes the lane byte as 0 and continues normally. `err` clears on the next accepted `start`.
- Without the macro: the FSM waits indefinitely and `err` is tied to 0.

Decomposition:
- Shared package `requant_pkg`:
  - FSM state enum.
  - LANES=4, BYTE_W=8.
  - INT8_MIN and INT8_MAX constants.
- One natural sub-module, `requant_clamp_pack`: offset add, clamp and byte-lane insert, combinational plus the packing register.

Test Plan:
- SRDHM/RDBPOT behavioural models with 5 and 3 cycle latency:
  - Stimulus: acc=100, multiplier=0x40000000, shift=1, offset=-128, range [-128,127].
  - Response: byte 0x99 (-103).
- Saturation:
  - Stimulus: lanes {1000000, -1000000, 0, 7}, multiplier=0x7FFFFFFF, shift=0, offset=0.
  - Response: q_data=0x0700807F (lane 0 in byte 0).
- Multi-row sweep:
  - Stimulus: count=3, c_base=0xFFF, q_base=0x010.
  - Response: C reads at 0xFFF, 0x000, 0x001; writes at 0x010, 0x011, 0x012; exactly one `done`.
- count=0 and start-while-busy:
  - Response: count=0 gives `done` 2 cycles after `start` with no writes.
  - Response: a second `start` mid-run is ignored (config unchanged, one `done`).
- Reset mid-operation:
  - Stimulus: drop `rst_n` during MUL_WAIT of row 1.
  - Response: all outputs 0 asynchronously; no `q_wr_en` afterwards; a clean rerun succeeds.
- Watchdog (REQUANT_WATCHDOG_EN):
  - Stimulus: SRDHM model never returns done on lane 2.
  - Response: `err`=1 after 64 cycles, lane-2 byte = 0x00, the run completes.
